// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS fetch/hazard control path.
// Included by the hazard controller and the load-use comparator.
package mips_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;

  // Fill bit for a saturated performance counter.
  localparam logic CNT_SAT = 1'b1;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    HALT,
    STEP
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: the instruction in ID reads the register
// that the load currently in EX has not yet written.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use
);

  assign load_use = idex_memread
                 && (idex_rt != '0)
                 && ((idex_rt == ifid_rs)
                  || (idex_rt == ifid_rt));

endmodule

// File: rtl/if_hazard_control.sv
// Fetch-stage sequencer: stall, redirect, squash and debug halt/step
// control for the PC and IF/ID registers, plus perf counters.
module if_hazard_control
  import mips_pkg::*;
#(
  parameter int ADDR_W            = ADDR_W_DEF,
  parameter int REG_W             = REG_W_DEF,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idex_memread,
  input  logic [REG_W-1:0]  idex_rt,
  input  logic [REG_W-1:0]  ifid_rs,
  input  logic [REG_W-1:0]  ifid_rt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_id,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt_req,
  input  logic              step_req,
  output logic              pc_write,
  output logic              writeIFID,
  output logic              flush_ifid,
  output logic              bubble_idex,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] PCJump,
  output logic              opcjump,
  output logic [ADDR_W-1:0] jumpAdd,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int SCW = (LOAD_STALL_CYCLES > 1)
                     ? $clog2(LOAD_STALL_CYCLES) : 1;
  localparam logic [SCW-1:0] StallInit =
    SCW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{CNT_SAT}};

  state_e           state_q, state_d;
  logic [SCW-1:0]   stall_cnt_q, stall_cnt_d;
  logic             ret_halt_q, ret_halt_d;
  logic             step_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             load_use;
  logic             stall_inc;
  logic             flush_inc;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_lud (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use     (load_use)
  );

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    ret_halt_d  = ret_halt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b0;
    writeIFID   = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    PCSrc       = 1'b0;
    PCJump      = '0;
    opcjump     = 1'b0;
    jumpAdd     = '0;
    halted      = 1'b0;
    if (reset) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      state_d     = RUN;
    end else begin
      unique case (state_q)
        RUN, STEP: begin
          pc_write  = 1'b1;
          writeIFID = 1'b1;
          state_d   = RUN;
          if (branch_taken) begin
            PCSrc       = 1'b1;
            PCJump      = branch_target;
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            writeIFID   = 1'b0;
            bubble_idex = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d     = STALL;
              stall_cnt_d = StallInit;
              ret_halt_d  = (state_q == STEP);
            end
          end else if (jump_id) begin
            opcjump    = 1'b1;
            jumpAdd    = jump_target;
            flush_ifid = 1'b1;
            flush_inc  = 1'b1;
          end else if (halt_req && state_q == RUN) begin
            pc_write    = 1'b0;
            writeIFID   = 1'b0;
            bubble_idex = 1'b1;
            state_d     = HALT;
          end
          // A step lasts one cycle unless it parked in STALL.
          if (state_q == STEP && state_d == RUN && halt_req)
            state_d = HALT;
        end
        STALL: begin
          if (branch_taken) begin
            pc_write    = 1'b1;
            writeIFID   = 1'b1;
            PCSrc       = 1'b1;
            PCJump      = branch_target;
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            flush_inc   = 1'b1;
            state_d     = RUN;
          end else begin
            bubble_idex = 1'b1;
            stall_inc   = 1'b1;
            stall_cnt_d = stall_cnt_q - SCW'(1);
            if (stall_cnt_q == SCW'(1))
              state_d = (ret_halt_q && halt_req) ? HALT : RUN;
          end
        end
        HALT: begin
          halted      = 1'b1;
          bubble_idex = 1'b1;
          if (!halt_req)
            state_d = RUN;
          else if (step_req && !step_q)
            state_d = STEP;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_count_d =
    (stall_inc && stall_count_q != CntMax)
    ? stall_count_q + CNT_W'(1) : stall_count_q;
  assign flush_count_d =
    (flush_inc && flush_count_q != CntMax)
    ? flush_count_q + CNT_W'(1) : flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      stall_cnt_q   <= '0;
      ret_halt_q    <= 1'b0;
      step_q        <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      ret_halt_q    <= ret_halt_d;
      step_q        <= step_req;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_if_hazard_control.sv
// Bench for if_hazard_control: two instances (1-cycle and 3-cycle
// load stall, 16- and 4-bit counters) against a behavioural model.
module tb_if_hazard_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mr, bt, jid, hreq, sreq;
  logic [4:0] irt, rs, rt;
  logic [9:0] btg, jtg;

  logic       a_pcw, a_wif, a_fl, a_bub, a_pcs, a_opj, a_hlt;
  logic [9:0] a_pcj, a_ja;
  logic [15:0] a_sc, a_fc;
  logic       b_pcw, b_wif, b_fl, b_bub, b_pcs, b_opj, b_hlt;
  logic [9:0] b_pcj, b_ja;
  logic [3:0] b_sc, b_fc;

  int vectors = 0;
  int miscompares = 0;

  if_hazard_control #(
    .ADDR_W(10), .REG_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)
  ) u1 (
    .clk(clk), .reset(rst), .idex_memread(mr), .idex_rt(irt),
    .ifid_rs(rs), .ifid_rt(rt), .branch_taken(bt),
    .branch_target(btg), .jump_id(jid), .jump_target(jtg),
    .halt_req(hreq), .step_req(sreq), .pc_write(a_pcw),
    .writeIFID(a_wif), .flush_ifid(a_fl), .bubble_idex(a_bub),
    .PCSrc(a_pcs), .PCJump(a_pcj), .opcjump(a_opj),
    .jumpAdd(a_ja), .halted(a_hlt), .stall_count(a_sc),
    .flush_count(a_fc)
  );

  if_hazard_control #(
    .ADDR_W(10), .REG_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(4)
  ) u3 (
    .clk(clk), .reset(rst), .idex_memread(mr), .idex_rt(irt),
    .ifid_rs(rs), .ifid_rt(rt), .branch_taken(bt),
    .branch_target(btg), .jump_id(jid), .jump_target(jtg),
    .halt_req(hreq), .step_req(sreq), .pc_write(b_pcw),
    .writeIFID(b_wif), .flush_ifid(b_fl), .bubble_idex(b_bub),
    .PCSrc(b_pcs), .PCJump(b_pcj), .opcjump(b_opj),
    .jumpAdd(b_ja), .halted(b_hlt), .stall_count(b_sc),
    .flush_count(b_fc)
  );

  typedef struct packed {
    logic pcw, wif, fl, bub, pcs;
    logic [9:0] pcj;
    logic opj;
    logic [9:0] ja;
    logic hlt;
    logic [15:0] sc, fc;
  } out_t;

  typedef struct packed {
    bit halted;
    bit stepping;
    int stall_left;
    bit back_halt;
    bit step_prev;
    int scnt;
    int fcnt;
  } mdl_t;

  out_t d1, d3;
  assign d1 = {a_pcw, a_wif, a_fl, a_bub, a_pcs, a_pcj, a_opj,
               a_ja, a_hlt, a_sc, a_fc};
  assign d3 = {b_pcw, b_wif, b_fl, b_bub, b_pcs, b_pcj, b_opj,
               b_ja, b_hlt, 12'd0, b_sc, 12'd0, b_fc};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic cmp(input string t, input out_t a, input out_t e);
    chk({t, ".pc_write"}, 32'(a.pcw), 32'(e.pcw));
    chk({t, ".writeIFID"}, 32'(a.wif), 32'(e.wif));
    chk({t, ".flush_ifid"}, 32'(a.fl), 32'(e.fl));
    chk({t, ".bubble_idex"}, 32'(a.bub), 32'(e.bub));
    chk({t, ".PCSrc"}, 32'(a.pcs), 32'(e.pcs));
    chk({t, ".PCJump"}, 32'(a.pcj), 32'(e.pcj));
    chk({t, ".opcjump"}, 32'(a.opj), 32'(e.opj));
    chk({t, ".jumpAdd"}, 32'(a.ja), 32'(e.ja));
    chk({t, ".halted"}, 32'(a.hlt), 32'(e.hlt));
    chk({t, ".stall_count"}, 32'(a.sc), 32'(e.sc));
    chk({t, ".flush_count"}, 32'(a.fc), 32'(e.fc));
  endtask

  function automatic int bump(input int v, input int cmax);
    return (v < cmax) ? v + 1 : v;
  endfunction

  // Expected outputs for this cycle and the controller's situation
  // after the coming edge, from the current inputs.
  function automatic void model(input int L, input int cmax,
                                input mdl_t m, output out_t o,
                                output mdl_t n);
    bit lu;
    o = '0;
    n = m;
    o.sc = 16'(m.scnt);
    o.fc = 16'(m.fcnt);
    if (rst) begin
      o.fl = 1'b1;
      o.bub = 1'b1;
      n = '0;
      return;
    end
    n.step_prev = sreq;
    lu = mr && irt != 0 && (irt == rs || irt == rt);
    if (m.halted) begin
      o.hlt = 1'b1;
      o.bub = 1'b1;
      if (!hreq) n.halted = 1'b0;
      else if (sreq && !m.step_prev) begin
        n.halted = 1'b0;
        n.stepping = 1'b1;
      end
    end else if (m.stall_left > 0) begin
      if (bt) begin
        o.pcw = 1; o.wif = 1; o.pcs = 1; o.pcj = btg;
        o.fl = 1; o.bub = 1;
        n.fcnt = bump(m.fcnt, cmax);
        n.stall_left = 0;
      end else begin
        o.bub = 1'b1;
        n.scnt = bump(m.scnt, cmax);
        n.stall_left = m.stall_left - 1;
        if (n.stall_left == 0 && m.back_halt && hreq)
          n.halted = 1'b1;
      end
    end else begin
      o.pcw = 1'b1;
      o.wif = 1'b1;
      n.stepping = 1'b0;
      if (bt) begin
        o.pcs = 1; o.pcj = btg; o.fl = 1; o.bub = 1;
        n.fcnt = bump(m.fcnt, cmax);
      end else if (lu) begin
        o.pcw = 0; o.wif = 0; o.bub = 1;
        n.scnt = bump(m.scnt, cmax);
        n.stall_left = L - 1;
        n.back_halt = m.stepping;
      end else if (jid) begin
        o.opj = 1; o.ja = jtg; o.fl = 1;
        n.fcnt = bump(m.fcnt, cmax);
      end else if (hreq && !m.stepping) begin
        o.pcw = 0; o.wif = 0; o.bub = 1;
        n.halted = 1'b1;
      end
      if (m.stepping && n.stall_left == 0 && hreq)
        n.halted = 1'b1;
    end
  endfunction

  mdl_t m1 = '0;
  mdl_t m3 = '0;

  always @(negedge clk) begin
    out_t e;
    mdl_t n;
    model(1, 65535, m1, e, n);
    cmp("L1", d1, e);
    m1 = n;
    model(3, 15, m3, e, n);
    cmp("L3", d3, e);
    m3 = n;
  end

  task automatic clear();
    mr = 0; irt = 0; rs = 0; rt = 0; bt = 0; btg = 0;
    jid = 0; jtg = 0; hreq = 0; sreq = 0;
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic load_use_pulse();
    mr = 1; irt = 5'd3; rt = 5'd3;
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    clear();
    // reset
    smp();
    chk("rst pc_write", 32'(a_pcw), 0);
    chk("rst flush_ifid", 32'(a_fl), 1);
    chk("rst bubble_idex", 32'(b_bub), 1);
    drv(); smp();
    chk("rst2 flush_ifid", 32'(b_fl), 1);
    drv(); rst = 1'b0; smp();
    chk("run pc_write", 32'(a_pcw), 1);
    chk("run writeIFID", 32'(a_wif), 1);
    chk("run stall_count", 32'(a_sc), 0);
    chk("run flush_count", 32'(b_fc), 0);
    // load-use, single-cycle stall
    drv(); mr = 1; irt = 5'd8; rs = 5'd8; smp();
    chk("lu pc_write", 32'(a_pcw), 0);
    chk("lu writeIFID", 32'(a_wif), 0);
    chk("lu bubble", 32'(a_bub), 1);
    drv(); clear(); smp();
    chk("lu stall_count", 32'(a_sc), 1);
    chk("lu resume", 32'(a_pcw), 1);
    drv(); mr = 1; smp();
    chk("rt0 no stall", 32'(a_pcw), 1);
    drv(); clear(); smp();
    chk("rt0 stall_count", 32'(a_sc), 1);
    chk("L3 stall_count", 32'(b_sc), 3);
    // branch beats jump
    drv(); bt = 1; btg = 10'h05A; jid = 1; jtg = 10'h100; smp();
    chk("br PCSrc", 32'(a_pcs), 1);
    chk("br PCJump", 32'(a_pcj), 32'h05A);
    chk("br opcjump", 32'(a_opj), 0);
    chk("br flush", 32'(a_fl), 1);
    chk("br bubble", 32'(a_bub), 1);
    drv(); clear(); smp();
    chk("br flush_count", 32'(a_fc), 1);
    // lone jump
    drv(); jid = 1; jtg = 10'h3FF; smp();
    chk("j opcjump", 32'(a_opj), 1);
    chk("j jumpAdd", 32'(a_ja), 32'h3FF);
    chk("j flush", 32'(a_fl), 1);
    chk("j bubble", 32'(a_bub), 0);
    chk("j PCJump", 32'(a_pcj), 0);
    drv(); clear(); smp();
    chk("j flush_count", 32'(a_fc), 2);
    // three-cycle stall
    drv(); load_use_pulse(); smp();
    chk("s3 c1", 32'(b_pcw), 0);
    drv(); clear(); smp();
    chk("s3 c2", 32'(b_pcw), 0);
    chk("s3 c2 bubble", 32'(b_bub), 1);
    drv(); smp();
    chk("s3 c3", 32'(b_pcw), 0);
    drv(); smp();
    chk("s3 resume", 32'(b_pcw), 1);
    chk("s3 stall_count", 32'(b_sc), 6);
    // branch aborts the stall
    drv(); load_use_pulse();
    drv(); clear(); bt = 1; btg = 10'h123; smp();
    chk("abort PCSrc", 32'(b_pcs), 1);
    chk("abort PCJump", 32'(b_pcj), 32'h123);
    chk("abort pc_write", 32'(b_pcw), 1);
    drv(); clear(); smp();
    chk("abort run", 32'(b_pcw), 1);
    chk("abort stall_count", 32'(b_sc), 7);
    chk("abort flush_count", 32'(b_fc), 3);
    chk("L1 stall_count", 32'(a_sc), 3);
    // saturate the 4-bit counter
    for (int i = 0; i < 4; i++) begin
      drv(); load_use_pulse();
      drv(); clear();
      drv();
    end
    smp();
    chk("sat stall_count", 32'(b_sc), 15);
    chk("L1 stall_count 2", 32'(a_sc), 7);
    // halt and single-step
    drv(); clear(); hreq = 1; smp();
    chk("h pc_write", 32'(a_pcw), 0);
    chk("h not yet", 32'(a_hlt), 0);
    drv(); smp();
    chk("h halted", 32'(a_hlt), 1);
    chk("h halted L3", 32'(b_hlt), 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drv(); sreq = (i == 0 || i == 4); smp();
      cnt += int'(a_pcw);
    end
    chk("two steps", 32'(cnt), 2);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drv(); sreq = 1; smp();
      cnt += int'(a_pcw);
    end
    chk("held step", 32'(cnt), 1);
    chk("h frozen", 32'(a_sc), 7);
    drv(); sreq = 0; hreq = 0; smp();
    chk("unhalt", 32'(a_hlt), 1);
    drv(); smp();
    chk("rerun halted", 32'(a_hlt), 0);
    chk("rerun pc_write", 32'(a_pcw), 1);
    // randomized traffic
    repeat (4000) begin
      drv();
      rst  = ($urandom_range(0, 199) == 0);
      mr   = ($urandom_range(0, 2) == 0);
      irt  = 5'($urandom_range(0, 3));
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      bt   = ($urandom_range(0, 7) == 0);
      btg  = 10'($urandom);
      jid  = ($urandom_range(0, 5) == 0);
      jtg  = 10'($urandom);
      if ($urandom_range(0, 15) == 0) hreq = !hreq;
      sreq = ($urandom_range(0, 3) == 0);
    end
    drv(); rst = 0; clear(); smp();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
